// File: rtl/shift_acc_pkg.sv
// Shared types and helpers for the shift_accumulator datapath.
package shift_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Width needed to hold a beat count in the range 0..max_terms.
    function automatic int count_w(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/NBitAdder.sv
// Ripple-carry adder; answer carries one extra MSB holding the carry-out.
module NBitAdder #(
    parameter int bitsize = 8
) (
    input  logic [bitsize-1:0] a,
    input  logic [bitsize-1:0] b,
    output logic [bitsize:0]   answer
);

    logic [bitsize:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < bitsize; gi++) begin : g_bit
            assign answer[gi]   = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign answer[bitsize] = carry[bitsize];

endmodule

// File: rtl/shift_accumulator.sv
// Packet accumulator of operand<<shift beats with a valid/ready result port.
// Build option: define SHIFT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module shift_accumulator
    import shift_acc_pkg::*;
#(
    parameter int BITSIZE   = 8,
    parameter int SHIFT_W   = 3,
    parameter int ACC_WIDTH = 20,
    parameter int MAX_TERMS = 16,
    localparam int CNT_W    = count_w(MAX_TERMS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITSIZE-1:0]   in_operand,
    input  logic [SHIFT_W-1:0]   in_shift,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    state_t                 state_reg, state_next;
    logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   ovf_reg, ovf_next;
    logic [ACC_WIDTH-1:0]   out_sum_reg;
    logic [CNT_W-1:0]       out_count_reg;
    logic                   out_ovf_reg;
    logic [ACC_WIDTH-1:0]   term;
    logic [ACC_WIDTH:0]     sum_full;
    logic                   carry;
    logic                   accept;
    logic                   release_out;

    assign term = ACC_WIDTH'(in_operand) << in_shift;

    NBitAdder #(.bitsize(ACC_WIDTH)) u_adder (
        .a      (acc_reg),
        .b      (term),
        .answer (sum_full)
    );

    assign carry = sum_full[ACC_WIDTH];

    always_comb begin
        ovf_next = ovf_reg | carry;
`ifdef SHIFT_ACC_SATURATE_EN
        // Once clamped, stay at full scale for the rest of the packet.
        if (carry || ovf_reg) begin
            acc_next = '1;
        end else begin
            acc_next = sum_full[ACC_WIDTH-1:0];
        end
`else
        acc_next = sum_full[ACC_WIDTH-1:0];
`endif
        if (count_reg == CNT_W'(MAX_TERMS)) begin
            count_next = count_reg;
        end else begin
            count_next = count_reg + 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        in_ready    = (state_reg != OUT);
        accept      = in_valid && (state_reg != OUT);
        release_out = (state_reg == OUT) && out_ready;
        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = in_last ? OUT : ACCUM;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
        end else if (accept) begin
            acc_reg   <= acc_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            if (in_last) begin
                out_sum_reg   <= acc_next;
                out_count_reg <= count_next;
                out_ovf_reg   <= ovf_next;
            end
        end else if (release_out) begin
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end
    end

    assign out_valid = (state_reg == OUT);
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_shift_accumulator.sv
// Scoreboard bench for shift_accumulator: default instance plus a 10-bit accumulator instance.
module tb_shift_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [7:0]  in_operand;
    logic [2:0]  in_shift;
    logic [19:0] out_sum;
    logic [4:0]  out_count;

    logic        in_valid_w, in_ready_w, in_last_w, out_valid_w, out_ready_w, out_ovf_w;
    logic [7:0]  in_operand_w;
    logic [2:0]  in_shift_w;
    logic [9:0]  out_sum_w;
    logic [4:0]  out_count_w;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t q_w[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    shift_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_operand(in_operand), .in_shift(in_shift), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    shift_accumulator #(.ACC_WIDTH(10)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_operand(in_operand_w), .in_shift(in_shift_w), .in_last(in_last_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_sum(out_sum_w),
        .out_count(out_count_w), .out_ovf(out_ovf_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic push(input int sum, input int cnt, input logic ovf);
        exp_t e;
        e.sum = sum;
        e.cnt = cnt;
        e.ovf = ovf;
        q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic send(input int op, input int sh, input logic last);
        int waited = 0;
        in_valid   = 1'b1;
        in_operand = op[7:0];
        in_shift   = sh[2:0];
        in_last    = last;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got sum %0d with empty scoreboard, expected none", out_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(out_sum), e.sum);
                chk("count", 32'(out_count), e.cnt);
                chk("ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_w && out_ready_w) begin
            if (q_w.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result_w: got sum %0d with empty scoreboard, expected none", out_sum_w);
            end else begin
                exp_t e;
                e = q_w.pop_front();
                chk("w_sum", 32'(out_sum_w), e.sum);
                chk("w_count", 32'(out_count_w), e.cnt);
                chk("w_ovf", 32'(out_ovf_w), 32'(e.ovf));
            end
        end
    end

    initial begin
        exp_t e;
        int   waited;
        rst_n = 1'b0;
        in_valid = 1'b0; in_operand = '0; in_shift = '0; in_last = 1'b0; out_ready = 1'b0;
        in_valid_w = 1'b0; in_operand_w = '0; in_shift_w = '0; in_last_w = 1'b0; out_ready_w = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: three-beat packet, result one cycle after last beat
        out_ready = 1'b1;
        send(5, 0, 1'b0);
        send(3, 2, 1'b0);
        push(145, 3, 1'b0);
        send(1, 7, 1'b1);
        chk("t1_latency_valid", 32'(out_valid), 1);
        @(posedge clk); #1;

        // 2: single beat, held off by out_ready
        out_ready = 1'b0;
        push(32640, 1, 1'b0);
        send(255, 7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("t2_in_ready_low", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_in_ready_back", 32'(in_ready), 1);
        chk("t2_valid_drop", 32'(out_valid), 0);
        chk("t2_sum_hold", 32'(out_sum), 32640);

        // 3: overflow on the 10-bit instance
        out_ready_w  = 1'b1;
        in_valid_w   = 1'b1;
        in_operand_w = 8'd255;
        in_shift_w   = 3'd2;
        in_last_w    = 1'b0;
        @(posedge clk); #1;
        in_last_w = 1'b1;
        e.cnt = 2;
        e.ovf = 1'b1;
`ifdef SHIFT_ACC_SATURATE_EN
        e.sum = 1023;
`else
        e.sum = 1016;
`endif
        q_w.push_back(e);
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        in_last_w  = 1'b0;
        @(posedge clk); #1;

        // 4: stalled output stays stable and blocks new beats
        out_ready = 1'b0;
        send(5, 0, 1'b0);
        push(17, 2, 1'b0);
        send(3, 2, 1'b1);
        in_valid = 1'b1; in_operand = 8'd99; in_shift = 3'd1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid_held", 32'(out_valid), 1);
            chk("t4_sum_stable", 32'(out_sum), 17);
            chk("t4_in_ready_low", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        push(1, 1, 1'b0);
        send(1, 0, 1'b1);
        @(posedge clk); #1;

        // 5: count saturates at 16
        for (int i = 0; i < 19; i++) send(1, 0, 1'b0);
        push(20, 16, 1'b0);
        send(1, 0, 1'b1);
        @(posedge clk); #1;

        // 6: reset mid-packet discards partial sum
        send(5, 0, 1'b0);
        send(3, 0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_out_sum", 32'(out_sum), 0);
        chk("t6_out_count", 32'(out_count), 0);
        chk("t6_out_ovf", 32'(out_ovf), 0);
        chk("t6_in_ready", 32'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push(14, 1, 1'b0);
        send(7, 1, 1'b1);

        waited = 0;
        while ((q.size() != 0 || q_w.size() != 0) && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("scoreboard_left", q.size() + q_w.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
